// File: rtl/mem_stage_pkg.sv
// Shared encodings, state type and lane helpers for the MEM pipeline stage.
package mem_stage_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned BE_W       = DATA_W / 8;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // Access context held while the memory request is outstanding.
    typedef struct packed {
        logic [DATA_W-1:0]     alu_result;
        logic                  mem_to_reg;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] write_reg;
        logic                  is_load;
        logic [1:0]            size;
        logic                  is_unsigned;
    } mem_ctrl_t;

    function automatic logic [BE_W-1:0] byte_enable(input logic [1:0] size,
                                                    input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: byte_enable = 4'b0001 << addr_lo;
            SIZE_HALF: byte_enable = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   byte_enable = 4'b1111;
        endcase
    endfunction

    // Reserved size 2'b11 behaves as a word.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = addr_lo[0];
            default:   is_misaligned = |addr_lo;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] store_lanes(input logic [1:0]        size,
                                                      input logic [DATA_W-1:0] data);
        case (size)
            SIZE_BYTE: store_lanes = {4{data[7:0]}};
            SIZE_HALF: store_lanes = {2{data[15:0]}};
            default:   store_lanes = data;
        endcase
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_align_ext
    import mem_stage_pkg::*;
(
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    output logic [DATA_W-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_bit;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        sign_bit = 1'b0;
        case (size_i)
            SIZE_BYTE: begin
                sign_bit = byte_sel[7] & ~unsigned_i;
                data_o   = {{24{sign_bit}}, byte_sel};
            end
            SIZE_HALF: begin
                sign_bit = half_sel[15] & ~unsigned_i;
                data_o   = {{16{sign_bit}}, half_sel};
            end
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores over a req/ack port and registers MEM/WB.
module mem_access_stage
    import mem_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ex_valid,
    input  logic [DATA_W-1:0]     ex_alu_result,
    input  logic [DATA_W-1:0]     ex_store_data,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic [1:0]            ex_size,
    input  logic                  ex_unsigned,
    input  logic                  ex_mem_to_reg,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_write_reg,
    output logic                  mem_stall,
    output logic                  dm_req,
    output logic                  dm_we,
    output logic [DATA_W-1:0]     dm_addr,
    output logic [DATA_W-1:0]     dm_wdata,
    output logic [BE_W-1:0]       dm_be,
    input  logic                  dm_ack,
    input  logic [DATA_W-1:0]     dm_rdata,
    output logic                  wb_valid,
    output logic [DATA_W-1:0]     wb_read_data,
    output logic [DATA_W-1:0]     wb_alu_result,
    output logic                  wb_mem_to_reg,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_write_reg,
    output logic                  wb_misalign
);

    state_e                state_q, state_d;
    mem_ctrl_t             ctrl_q, ctrl_d;
    logic                  dm_req_q, dm_req_d;
    logic                  dm_we_q, dm_we_d;
    logic [DATA_W-1:0]     dm_addr_q, dm_addr_d;
    logic [DATA_W-1:0]     dm_wdata_q, dm_wdata_d;
    logic [BE_W-1:0]       dm_be_q, dm_be_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0]     wb_read_data_q, wb_read_data_d;
    logic [DATA_W-1:0]     wb_alu_result_q, wb_alu_result_d;
    logic                  wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic                  wb_reg_write_q, wb_reg_write_d;
    logic [REG_ADDR_W-1:0] wb_write_reg_q, wb_write_reg_d;
    logic                  wb_misalign_q, wb_misalign_d;

    logic                  mem_op;
    logic                  misalign;
    logic [DATA_W-1:0]     load_data;

    assign mem_op   = ex_mem_read | ex_mem_write;
    assign misalign = mem_op & is_misaligned(ex_size, ex_alu_result[1:0]);

    load_align_ext u_load_align_ext (
        .rdata_i    (dm_rdata),
        .addr_lo_i  (ctrl_q.alu_result[1:0]),
        .size_i     (ctrl_q.size),
        .unsigned_i (ctrl_q.is_unsigned),
        .data_o     (load_data)
    );

    // State and pipeline registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            ctrl_q          <= '0;
            dm_req_q        <= 1'b0;
            dm_we_q         <= 1'b0;
            dm_addr_q       <= '0;
            dm_wdata_q      <= '0;
            dm_be_q         <= '0;
            wb_valid_q      <= 1'b0;
            wb_read_data_q  <= '0;
            wb_alu_result_q <= '0;
            wb_mem_to_reg_q <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_write_reg_q  <= '0;
            wb_misalign_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            ctrl_q          <= ctrl_d;
            dm_req_q        <= dm_req_d;
            dm_we_q         <= dm_we_d;
            dm_addr_q       <= dm_addr_d;
            dm_wdata_q      <= dm_wdata_d;
            dm_be_q         <= dm_be_d;
            wb_valid_q      <= wb_valid_d;
            wb_read_data_q  <= wb_read_data_d;
            wb_alu_result_q <= wb_alu_result_d;
            wb_mem_to_reg_q <= wb_mem_to_reg_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_write_reg_q  <= wb_write_reg_d;
            wb_misalign_q   <= wb_misalign_d;
        end
    end

    // Next-state, memory request and MEM/WB capture.
    always_comb begin
        state_d         = state_q;
        ctrl_d          = ctrl_q;
        dm_req_d        = dm_req_q;
        dm_we_d         = dm_we_q;
        dm_addr_d       = dm_addr_q;
        dm_wdata_d      = dm_wdata_q;
        dm_be_d         = dm_be_q;
        wb_valid_d      = wb_valid_q;
        wb_read_data_d  = wb_read_data_q;
        wb_alu_result_d = wb_alu_result_q;
        wb_mem_to_reg_d = wb_mem_to_reg_q;
        wb_reg_write_d  = wb_reg_write_q;
        wb_write_reg_d  = wb_write_reg_q;
        wb_misalign_d   = wb_misalign_q;
        mem_stall       = 1'b0;

        case (state_q)
            IDLE: begin
                if (ex_valid && mem_op && !misalign) begin
                    ctrl_d.alu_result  = ex_alu_result;
                    ctrl_d.mem_to_reg  = ex_mem_to_reg;
                    ctrl_d.reg_write   = ex_reg_write;
                    ctrl_d.write_reg   = ex_write_reg;
                    ctrl_d.is_load     = ex_mem_read;
                    ctrl_d.size        = ex_size;
                    ctrl_d.is_unsigned = ex_unsigned;
                    dm_req_d   = 1'b1;
                    dm_we_d    = ex_mem_write;
                    dm_addr_d  = {ex_alu_result[DATA_W-1:2], 2'b00};
                    dm_wdata_d = store_lanes(ex_size, ex_store_data);
                    dm_be_d    = ex_mem_write ? byte_enable(ex_size, ex_alu_result[1:0])
                                              : 4'b1111;
                    wb_valid_d = 1'b0;
                    mem_stall  = 1'b1;
                    state_d    = WAIT;
                end else if (ex_valid) begin
                    // ALU ops and misaligned accesses retire without touching memory.
                    wb_valid_d      = 1'b1;
                    wb_alu_result_d = ex_alu_result;
                    wb_mem_to_reg_d = ex_mem_to_reg;
                    wb_reg_write_d  = ex_reg_write & ~misalign;
                    wb_write_reg_d  = ex_write_reg;
                    wb_misalign_d   = misalign;
                end else begin
                    wb_valid_d = 1'b0;
                end
            end
            WAIT: begin
                mem_stall = ~dm_ack;
                if (dm_ack) begin
                    dm_req_d        = 1'b0;
                    wb_valid_d      = 1'b1;
                    wb_alu_result_d = ctrl_q.alu_result;
                    wb_mem_to_reg_d = ctrl_q.mem_to_reg;
                    wb_reg_write_d  = ctrl_q.reg_write;
                    wb_write_reg_d  = ctrl_q.write_reg;
                    wb_misalign_d   = 1'b0;
                    if (ctrl_q.is_load) begin
                        wb_read_data_d = load_data;
                    end
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign dm_req        = dm_req_q;
    assign dm_we         = dm_we_q;
    assign dm_addr       = dm_addr_q;
    assign dm_wdata      = dm_wdata_q;
    assign dm_be         = dm_be_q;
    assign wb_valid      = wb_valid_q;
    assign wb_read_data  = wb_read_data_q;
    assign wb_alu_result = wb_alu_result_q;
    assign wb_mem_to_reg = wb_mem_to_reg_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_write_reg  = wb_write_reg_q;
    assign wb_misalign   = wb_misalign_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed vector table, reset corners, random ops.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_size;
    logic        ex_unsigned;
    logic        ex_mem_to_reg;
    logic        ex_reg_write;
    logic [4:0]  ex_write_reg;
    logic        mem_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        wb_valid;
    logic [31:0] wb_read_data;
    logic [31:0] wb_alu_result;
    logic        wb_mem_to_reg;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic        wb_misalign;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ex_valid      (ex_valid),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_size       (ex_size),
        .ex_unsigned   (ex_unsigned),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_reg_write  (ex_reg_write),
        .ex_write_reg  (ex_write_reg),
        .mem_stall     (mem_stall),
        .dm_req        (dm_req),
        .dm_we         (dm_we),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_be         (dm_be),
        .dm_ack        (dm_ack),
        .dm_rdata      (dm_rdata),
        .wb_valid      (wb_valid),
        .wb_read_data  (wb_read_data),
        .wb_alu_result (wb_alu_result),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_reg_write  (wb_reg_write),
        .wb_write_reg  (wb_write_reg),
        .wb_misalign   (wb_misalign)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          nwait;
        logic        rw;
        logic        m2r;
        logic [4:0]  wreg;
    } op_t;

    typedef struct {
        op_t         op;
        int          e_stall;
        logic        e_req;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_rd;
        logic        e_mis;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_rd = 32'h0;
    vec_t        vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic op_t mk(input logic rd, input logic wr, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr,
                               input logic [31:0] sdata, input logic [31:0] rdata,
                               input int nwait, input logic rw, input logic m2r,
                               input logic [4:0] wreg);
        op_t o;
        o.rd = rd; o.wr = wr; o.size = size; o.uns = uns; o.addr = addr;
        o.sdata = sdata; o.rdata = rdata; o.nwait = nwait;
        o.rw = rw; o.m2r = m2r; o.wreg = wreg;
        return o;
    endfunction

    function automatic vec_t mkv(input op_t o, input int st, input logic rq,
                                 input logic [31:0] a, input logic [3:0] be,
                                 input logic [31:0] wd, input logic [31:0] rdv,
                                 input logic mis);
        vec_t v;
        v.op = o; v.e_stall = st; v.e_req = rq; v.e_addr = a; v.e_be = be;
        v.e_wdata = wd; v.e_rd = rdv; v.e_mis = mis;
        return v;
    endfunction

    // Reference model: derived from the access rules with plain arithmetic.
    function automatic logic model_mis(input op_t o);
        int a = int'(o.addr[1:0]);
        if (!(o.rd || o.wr)) return 1'b0;
        if (o.size == 2'd0)  return 1'b0;
        if (o.size == 2'd1)  return (a % 2) != 0;
        return a != 0;
    endfunction

    function automatic logic [3:0] model_be(input op_t o);
        int a = int'(o.addr[1:0]);
        if (!o.wr) return 4'hF;
        if (o.size == 2'd0) return 4'(1 << a);
        if (o.size == 2'd1) return 4'(3 << a);
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input op_t o);
        if (o.size == 2'd0) return 32'(o.sdata[7:0]) * 32'h0101_0101;
        if (o.size == 2'd1) return 32'(o.sdata[15:0]) * 32'h0001_0001;
        return o.sdata;
    endfunction

    function automatic logic [31:0] model_load(input op_t o);
        logic [31:0] w;
        logic [31:0] v;
        w = o.rdata >> (8 * int'(o.addr[1:0]));
        if (o.size == 2'd0) begin
            v = w % 256;
            if (!o.uns && v >= 128) v = v + 32'hFFFF_FF00;
            return v;
        end
        if (o.size == 2'd1) begin
            v = w % 65536;
            if (!o.uns && v >= 32768) v = v + 32'hFFFF_0000;
            return v;
        end
        return o.rdata;
    endfunction

    task automatic run_op(input op_t op, output int stalls, output int reqs,
                          output logic [31:0] oaddr, output logic owe,
                          output logic [3:0] obe, output logic [31:0] owd,
                          output logic unstable);
        logic done;
        done = 1'b0;
        stalls = 0; reqs = 0; oaddr = '0; owe = 1'b0; obe = '0; owd = '0; unstable = 1'b0;
        ex_valid      = 1'b1;
        ex_alu_result = op.addr;
        ex_store_data = op.sdata;
        ex_mem_read   = op.rd;
        ex_mem_write  = op.wr;
        ex_size       = op.size;
        ex_unsigned   = op.uns;
        ex_mem_to_reg = op.m2r;
        ex_reg_write  = op.rw;
        ex_write_reg  = op.wreg;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (dm_req) begin
                dm_ack   = (reqs == op.nwait);
                dm_rdata = (reqs == op.nwait) ? op.rdata : $urandom;
            end else begin
                dm_ack   = 1'($urandom_range(0, 1));
                dm_rdata = $urandom;
            end
            @(negedge clk);
            if (mem_stall) stalls++;
            if (dm_req) begin
                if (reqs == 0) begin
                    oaddr = dm_addr; owe = dm_we; obe = dm_be; owd = dm_wdata;
                end else if (dm_addr !== oaddr || dm_we !== owe || dm_be !== obe ||
                             dm_wdata !== owd) begin
                    unstable = 1'b1;
                end
                reqs++;
            end
            done = !mem_stall;
            @(posedge clk); #1;
            if (done) break;
        end
        chk("op_completes", 32'(done), 32'd1);
        ex_valid = 1'b0;
        dm_ack   = 1'b0;
    endtask

    task automatic check_slot(input string tag, input op_t o, input int e_stall,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic [3:0] e_be, input logic [31:0] e_wd,
                              input logic e_mis, input logic [31:0] e_rd);
        int          stalls, reqs;
        logic [31:0] oaddr, owd;
        logic        owe, unstable;
        logic [3:0]  obe;
        run_op(o, stalls, reqs, oaddr, owe, obe, owd, unstable);
        chk({tag, ".stall_cycles"}, 32'(stalls), 32'(e_stall));
        chk({tag, ".req_cycles"}, 32'(reqs), e_req ? 32'(o.nwait + 1) : 32'd0);
        if (e_req) begin
            chk({tag, ".dm_addr"}, oaddr, e_addr);
            chk({tag, ".dm_we"}, 32'(owe), 32'(o.wr));
            chk({tag, ".dm_be"}, 32'(obe), 32'(e_be));
            if (o.wr) chk({tag, ".dm_wdata"}, owd, e_wd);
            chk({tag, ".dm_stable"}, 32'(unstable), 32'd0);
        end
        chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
        chk({tag, ".wb_alu_result"}, wb_alu_result, o.addr);
        chk({tag, ".wb_mem_to_reg"}, 32'(wb_mem_to_reg), 32'(o.m2r));
        chk({tag, ".wb_reg_write"}, 32'(wb_reg_write), 32'(o.rw & ~e_mis));
        chk({tag, ".wb_write_reg"}, 32'(wb_write_reg), 32'(o.wreg));
        chk({tag, ".wb_misalign"}, 32'(wb_misalign), 32'(e_mis));
        chk({tag, ".wb_read_data"}, wb_read_data, e_rd);
    endtask

    task automatic idle_cycle();
        ex_valid      = 1'b0;
        ex_mem_read   = 1'($urandom_range(0, 1));
        ex_alu_result = $urandom;
        dm_ack        = 1'($urandom_range(0, 1));
        dm_rdata      = $urandom;
        @(negedge clk);
        chk("idle.mem_stall", 32'(mem_stall), 32'd0);
        chk("idle.dm_req", 32'(dm_req), 32'd0);
        @(posedge clk); #1;
        chk("idle.wb_valid", 32'(wb_valid), 32'd0);
        chk("idle.wb_read_data", wb_read_data, model_rd);
        dm_ack = 1'b0;
    endtask

    initial begin
        logic [31:0] e_rd;
        op_t         o;
        logic        mis;

        vecs[0]  = mkv(mk(0,0,2'd2,0,32'h0000_1234,32'h0,32'h0,0,1,0,5'd3),
                       0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 0);
        vecs[1]  = mkv(mk(1,0,2'd0,0,32'h0000_0103,32'h0,32'h80FF_0000,3,1,1,5'd5),
                       4, 1, 32'h0000_0100, 4'hF, 32'h0, 32'hFFFF_FF80, 0);
        vecs[2]  = mkv(mk(1,0,2'd0,1,32'h0000_0103,32'h0,32'h80FF_0000,3,1,1,5'd6),
                       4, 1, 32'h0000_0100, 4'hF, 32'h0, 32'h0000_0080, 0);
        vecs[3]  = mkv(mk(0,1,2'd1,0,32'h0000_0202,32'h0000_ABCD,32'h0,2,0,0,5'd0),
                       3, 1, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0, 0);
        vecs[4]  = mkv(mk(1,0,2'd2,0,32'h0000_0105,32'h0,32'h1111_1111,1,1,1,5'd7),
                       0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1);
        vecs[5]  = mkv(mk(1,0,2'd1,0,32'h0000_0102,32'h0,32'h80FF_0000,1,1,1,5'd8),
                       2, 1, 32'h0000_0100, 4'hF, 32'h0, 32'hFFFF_80FF, 0);
        vecs[6]  = mkv(mk(1,0,2'd1,1,32'h0000_0102,32'h0,32'h80FF_0000,0,1,1,5'd9),
                       1, 1, 32'h0000_0100, 4'hF, 32'h0, 32'h0000_80FF, 0);
        vecs[7]  = mkv(mk(1,0,2'd1,0,32'h0000_0100,32'h0,32'h1234_8765,1,1,1,5'd10),
                       2, 1, 32'h0000_0100, 4'hF, 32'h0, 32'hFFFF_8765, 0);
        vecs[8]  = mkv(mk(1,0,2'd2,0,32'h0000_0200,32'h0,32'hDEAD_BEEF,2,1,1,5'd11),
                       3, 1, 32'h0000_0200, 4'hF, 32'h0, 32'hDEAD_BEEF, 0);
        vecs[9]  = mkv(mk(0,1,2'd0,0,32'h0000_0301,32'hFFFF_FFA5,32'h0,1,0,0,5'd0),
                       2, 1, 32'h0000_0300, 4'b0010, 32'hA5A5_A5A5, 32'h0, 0);
        vecs[10] = mkv(mk(0,1,2'd2,0,32'h0000_0400,32'h1122_3344,32'h0,0,0,0,5'd0),
                       1, 1, 32'h0000_0400, 4'hF, 32'h1122_3344, 32'h0, 0);
        vecs[11] = mkv(mk(1,0,2'd3,1,32'h0000_0108,32'h0,32'hCAFE_F00D,1,1,1,5'd12),
                       2, 1, 32'h0000_0108, 4'hF, 32'h0, 32'hCAFE_F00D, 0);
        vecs[12] = mkv(mk(0,1,2'd3,0,32'h0000_010A,32'h5555_5555,32'h0,1,0,0,5'd0),
                       0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1);
        vecs[13] = mkv(mk(0,1,2'd1,0,32'h0000_0201,32'h0000_1234,32'h0,1,1,0,5'd13),
                       0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1);
        vecs[14] = mkv(mk(1,0,2'd0,1,32'h0000_0102,32'h0,32'h00AB_0000,2,1,1,5'd14),
                       3, 1, 32'h0000_0100, 4'hF, 32'h0, 32'h0000_00AB, 0);
        vecs[15] = mkv(mk(1,0,2'd0,0,32'h0000_0100,32'h0,32'h0000_007F,0,1,1,5'd15),
                       1, 1, 32'h0000_0100, 4'hF, 32'h0, 32'h0000_007F, 0);

        // Reset with a stray ack asserted.
        reset_n = 1'b0; ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0;
        ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_size = 2'd0; ex_unsigned = 1'b0;
        ex_mem_to_reg = 1'b0; ex_reg_write = 1'b0; ex_write_reg = '0;
        dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.mem_stall", 32'(mem_stall), 32'd0);
        chk("rst.dm_req", 32'(dm_req), 32'd0);
        chk("rst.dm_we", 32'(dm_we), 32'd0);
        chk("rst.dm_addr", dm_addr, 32'd0);
        chk("rst.dm_wdata", dm_wdata, 32'd0);
        chk("rst.dm_be", 32'(dm_be), 32'd0);
        chk("rst.wb_valid", 32'(wb_valid), 32'd0);
        chk("rst.wb_read_data", wb_read_data, 32'd0);
        chk("rst.wb_alu_result", wb_alu_result, 32'd0);
        chk("rst.wb_ctrl", {wb_mem_to_reg, wb_reg_write, wb_misalign, wb_write_reg}, 32'd0);
        reset_n = 1'b1; dm_ack = 1'b0;
        @(posedge clk); #1;

        // Directed vector table, issued back to back.
        for (int i = 0; i < 16; i++) begin
            o = vecs[i].op;
            e_rd = (o.rd && !vecs[i].e_mis) ? vecs[i].e_rd : model_rd;
            model_rd = e_rd;
            check_slot($sformatf("vec%0d", i), o, vecs[i].e_stall, vecs[i].e_req,
                       vecs[i].e_addr, vecs[i].e_be, vecs[i].e_wdata, vecs[i].e_mis, e_rd);
        end
        idle_cycle();

        // Reset while a load is outstanding; the late ack must be ignored.
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_size = 2'd2;
        ex_alu_result = 32'h0000_0500; ex_reg_write = 1'b1; ex_mem_to_reg = 1'b1;
        dm_ack = 1'b0;
        @(posedge clk); #1;
        chk("rstwait.dm_req_before", 32'(dm_req), 32'd1);
        reset_n = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0;
        @(posedge clk); #1;
        chk("rstwait.dm_req_after", 32'(dm_req), 32'd0);
        chk("rstwait.wb_valid_after", 32'(wb_valid), 32'd0);
        reset_n = 1'b1;
        model_rd = 32'h0;
        @(posedge clk); #1;
        dm_ack = 1'b1; dm_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("rstwait.mem_stall_late_ack", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        chk("rstwait.wb_valid_late_ack", 32'(wb_valid), 32'd0);
        chk("rstwait.dm_req_late_ack", 32'(dm_req), 32'd0);
        chk("rstwait.wb_read_data", wb_read_data, 32'd0);
        dm_ack = 1'b0;

        // Random ops against the reference model.
        for (int n = 0; n < 300; n++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            o = mk(kind == 1, kind == 2, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, $urandom, int'($urandom_range(0, 4)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 31)));
            mis = model_mis(o);
            e_rd = (o.rd && !mis) ? model_load(o) : model_rd;
            model_rd = e_rd;
            check_slot("rand", o, ((o.rd || o.wr) && !mis) ? o.nwait + 1 : 0,
                       (o.rd || o.wr) && !mis, {o.addr[31:2], 2'b00},
                       model_be(o), model_wdata(o), mis, e_rd);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
